// File: rtl/bitcnt_seq.sv
// bitcnt_seq: multi-cycle bit-count unit (clz, ctz, zerocount, clo, cto,
// popcount) over a 2**ORDER-bit word, one 2**CORDER-bit chunk per clock.
// in_op = {inv, ctz, clz}; the word is inverted on capture when inv is set,
// so every op reduces to counting zero bits of the captured word.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE, where
// out_count/out_zero stay frozen until out_ready is seen.
//
// Build option: define BITCNT_EARLY_EXIT_EN to stop clz/ctz/clo/cto scans at
// the first nonzero chunk. Without it every legal op scans all chunks.
// Result values are the same in both builds.
module bitcnt_seq #(
  parameter int ORDER  = 5,
  parameter int CORDER = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [2**ORDER-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ORDER:0]        out_count,
  output logic                  out_zero
);

  localparam int W  = 2**ORDER;
  localparam int C  = 2**CORDER;
  localparam int N  = 2**(ORDER-CORDER);
  localparam int AW = ORDER + 1;
  localparam int CW = CORDER + 1;
  localparam int IW = (ORDER > CORDER) ? (ORDER - CORDER) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    e;        // effective word, captured on acceptance
  logic            op_clz;
  logic            op_ctz;
  logic [AW-1:0]   acc;
  logic [IW-1:0]   cnt;      // chunks already scanned
  logic            found;    // a nonzero chunk has been seen (clz/ctz ops)

  logic [C-1:0]    chunks [N];
  logic [IW-1:0]   idx;
  logic [C-1:0]    chunk;
  logic [CW-1:0]   lz, tz, zc, contrib;
  logic            lz_seen, tz_seen;
  logic            legal, dir, nz, last, term;
  logic [AW-1:0]   acc_next;

  // Split the captured word into chunks for indexed selection
  always_comb begin
    for (int i = 0; i < N; i++) chunks[i] = e[i*C +: C];
  end

  // Select the chunk for this cycle and count its leading, trailing and total zeros
  always_comb begin
    idx   = (op_clz && !op_ctz) ? (IW'(N-1) - cnt) : cnt;
    chunk = chunks[idx];
    lz = '0; tz = '0; zc = '0;
    lz_seen = 1'b0; tz_seen = 1'b0;
    for (int i = C-1; i >= 0; i--) begin
      if (!lz_seen) begin
        if (chunk[i]) lz_seen = 1'b1;
        else          lz = lz + CW'(1);
      end
    end
    for (int i = 0; i < C; i++) begin
      if (!tz_seen) begin
        if (chunk[i]) tz_seen = 1'b1;
        else          tz = tz + CW'(1);
      end
      zc = zc + CW'(!chunk[i]);
    end
  end

  // Per-cycle contribution, accumulator update and termination decision
  always_comb begin
    legal = op_clz | op_ctz;
    dir   = op_clz ^ op_ctz;
    nz    = |chunk;
    last  = (cnt == IW'(N-1));
    if (!legal)     contrib = '0;
    else if (!dir)  contrib = zc;
    else if (found) contrib = '0;   // past the first one bit: nothing more to add
    else if (op_clz) contrib = lz;
    else            contrib = tz;
    acc_next = acc + AW'(contrib);
`ifdef BITCNT_EARLY_EXIT_EN
    term = !legal || last || (dir && nz);
`else
    term = !legal || last;
`endif
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      out_zero  <= 1'b0;
      e         <= '0;
      op_clz    <= 1'b0;
      op_ctz    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      found     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            e        <= in_data ^ {W{in_op[2]}};
            op_clz   <= in_op[0];
            op_ctz   <= in_op[1];
            acc      <= '0;
            cnt      <= '0;
            found    <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          found <= found | nz;
          cnt   <= cnt + IW'(1);
          if (term) begin
            out_count <= acc_next;
            out_zero  <= ~|e;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
